// File: rtl/dma_cfg_pkg.sv
// Shared definitions for the DMA configuration slave: register offsets, bit
// positions, FSM state encodings and AXI response codes.
package dma_cfg_pkg;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_SRC    = 8'h04;
  localparam logic [7:0] OFS_DST    = 8'h08;
  localparam logic [7:0] OFS_QTY    = 8'h0C;
  localparam logic [7:0] OFS_STATUS = 8'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IE     = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_e;
  typedef enum logic       {RIDLE, RDATA}        rstate_e;

  // Expands a 4-bit byte strobe into a 32-bit lane mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/dma_cfg_if.sv
// AXI slave-side bundle; S2AXIin carries what the slave samples, S2AXIout
// carries what the slave drives.
interface inf_Slave #(
  parameter int ID_W  = 8,
  parameter int LEN_W = 8
);
  logic [31:0]      awaddr;
  logic [ID_W-1:0]  awid;
  logic             awvalid;
  logic             awready;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wlast;
  logic             wvalid;
  logic             wready;
  logic [ID_W-1:0]  bid;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic [31:0]      araddr;
  logic [ID_W-1:0]  arid;
  logic [LEN_W-1:0] arlen;
  logic             arvalid;
  logic             arready;
  logic [ID_W-1:0]  rid;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rlast;
  logic             rvalid;
  logic             rready;

  modport S2AXIin (
    input awaddr, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
          araddr, arid, arlen, arvalid, rready
  );
  modport S2AXIout (
    output awready, wready, bid, bresp, bvalid, arready,
           rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dma_cfg_regs.sv
// Register storage for the DMA descriptor plus the BUSY/DONE handshake with
// the DMA master and the level interrupt.
module dma_cfg_regs
  import dma_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_ofs,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        wr_err,
  input  logic [7:0]  rd_ofs,
  output logic [31:0] rd_data,
  output logic        rd_err,
  input  logic        dma_fin,
  output logic        dma_en,
  output logic [31:0] src_addr,
  output logic [31:0] dst_addr,
  output logic [31:0] data_qty,
  output logic        irq
);

  logic        ie;
  logic        busy;
  logic        done;
  logic [31:0] mask;
  logic [31:0] wr_bits;
  logic        start_req;
  logic        done_clr;

  assign mask      = strb_mask(wr_strb);
  assign wr_bits   = wr_data & mask;
  assign start_req = wr_en && (wr_ofs == OFS_CTRL) && wr_bits[CTRL_START] && !busy;
  assign done_clr  = wr_en && (wr_ofs == OFS_STATUS) && wr_bits[STATUS_DONE];
  assign irq       = done & ie;

  // Descriptor writes and restarts are refused while a transfer is in flight.
  always_comb begin
    wr_err = 1'b0;
    case (wr_ofs)
      OFS_CTRL:                   wr_err = busy & wr_bits[CTRL_START];
      OFS_SRC, OFS_DST, OFS_QTY:  wr_err = busy;
      OFS_STATUS:                 wr_err = 1'b0;
      default:                    wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_ofs)
      OFS_CTRL:   rd_data[CTRL_IE] = ie;
      OFS_SRC:    rd_data = src_addr;
      OFS_DST:    rd_data = dst_addr;
      OFS_QTY:    rd_data = data_qty;
      OFS_STATUS: begin
        rd_data[STATUS_DONE] = done;
        rd_data[STATUS_BUSY] = busy;
      end
      default:    rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dma_en   <= 1'b0;
      src_addr <= '0;
      dst_addr <= '0;
      data_qty <= '0;
    end else begin
      dma_en <= start_req;
      if (wr_en) begin
        case (wr_ofs)
          OFS_CTRL: if (mask[CTRL_IE]) ie <= wr_data[CTRL_IE];
          OFS_SRC:  if (!busy) src_addr <= (src_addr & ~mask) | wr_bits;
          OFS_DST:  if (!busy) dst_addr <= (dst_addr & ~mask) | wr_bits;
          OFS_QTY:  if (!busy) data_qty <= (data_qty & ~mask) | wr_bits;
          default: ;
        endcase
      end
      if (dma_fin)        busy <= 1'b0;
      else if (start_req) busy <= 1'b1;
      // Completion beats a simultaneous software clear so no DONE is lost.
      if (dma_fin)        done <= 1'b1;
      else if (done_clr)  done <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_cfg_slave.sv
// AXI slave front end for the DMA configuration registers: independent
// write (AW/W/B) and read (AR/R) state machines around dma_cfg_regs.
module dma_cfg_slave
  import dma_cfg_pkg::*;
#(
  parameter int OFS_MSB = 4,
  parameter int ID_W    = 8,
  parameter int LEN_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  inf_Slave.S2AXIin   s2axi_i,
  inf_Slave.S2AXIout  s2axi_o,
  input  logic        dma_fin_i,
  output logic        dma_en_o,
  output logic [31:0] src_addr_o,
  output logic [31:0] dst_addr_o,
  output logic [31:0] data_qty_o,
  output logic        irq_o
);

  wstate_e          wstate;
  logic             awready_q, wready_q, bvalid_q, werr_q;
  logic [1:0]       bresp_q;
  logic [ID_W-1:0]  bid_q;
  logic [7:0]       waddr_q;

  rstate_e          rstate;
  logic             arready_q, rvalid_q;
  logic [1:0]       rresp_q;
  logic [ID_W-1:0]  rid_q;
  logic [LEN_W-1:0] rlen_q, rcnt_q;
  logic [7:0]       raddr_q;
  logic [31:0]      rdata_q;

  logic [7:0]       aw_ofs, ar_ofs, rd_ofs;
  logic             wr_en, wr_err, rd_err;
  logic [31:0]      rd_data;
  logic             unused_addr_bits;

  // Only addr[OFS_MSB:2] selects a register; byte offset bits are ignored.
  assign aw_ofs = 8'({s2axi_i.awaddr[OFS_MSB:2], 2'b00});
  assign ar_ofs = 8'({s2axi_i.araddr[OFS_MSB:2], 2'b00});
  assign unused_addr_bits = ^{s2axi_i.awaddr[31:OFS_MSB+1], s2axi_i.awaddr[1:0],
                              s2axi_i.araddr[31:OFS_MSB+1], s2axi_i.araddr[1:0]};
  assign rd_ofs = (rstate == RIDLE) ? ar_ofs : raddr_q;
  assign wr_en  = s2axi_i.wvalid & wready_q;

  dma_cfg_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_ofs   (waddr_q),
    .wr_data  (s2axi_i.wdata),
    .wr_strb  (s2axi_i.wstrb),
    .wr_err   (wr_err),
    .rd_ofs   (rd_ofs),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .dma_fin  (dma_fin_i),
    .dma_en   (dma_en_o),
    .src_addr (src_addr_o),
    .dst_addr (dst_addr_o),
    .data_qty (data_qty_o),
    .irq      (irq_o)
  );

  // Error is sticky across a FIXED burst so any rejected beat yields SLVERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate    <= WIDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      werr_q    <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
      bid_q     <= '0;
      waddr_q   <= '0;
    end else begin
      case (wstate)
        WIDLE: begin
          awready_q <= 1'b1;
          if (s2axi_i.awvalid && awready_q) begin
            waddr_q   <= aw_ofs;
            bid_q     <= s2axi_i.awid;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate    <= WDATA;
          end
        end
        WDATA: begin
          if (wr_en) begin
            if (wr_err) werr_q <= 1'b1;
            if (s2axi_i.wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || wr_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              wstate   <= WRESP;
            end
          end
        end
        WRESP: begin
          if (s2axi_i.bready) begin
            bvalid_q <= 1'b0;
            wstate   <= WIDLE;
          end
        end
        default: wstate <= WIDLE;
      endcase
    end
  end

  // rdata is reloaded at each accepted beat so later beats see current values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate    <= RIDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (rstate)
        RIDLE: begin
          arready_q <= 1'b1;
          if (s2axi_i.arvalid && arready_q) begin
            raddr_q   <= ar_ofs;
            rid_q     <= s2axi_i.arid;
            rlen_q    <= s2axi_i.arlen;
            rcnt_q    <= '0;
            rdata_q   <= rd_data;
            rresp_q   <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rstate    <= RDATA;
          end
        end
        RDATA: begin
          if (s2axi_i.rready) begin
            if (rcnt_q == rlen_q) begin
              rvalid_q <= 1'b0;
              rstate   <= RIDLE;
            end else begin
              rcnt_q  <= rcnt_q + 1'b1;
              rdata_q <= rd_data;
              rresp_q <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
          end
        end
        default: rstate <= RIDLE;
      endcase
    end
  end

  assign s2axi_o.awready = awready_q;
  assign s2axi_o.wready  = wready_q;
  assign s2axi_o.bvalid  = bvalid_q;
  assign s2axi_o.bresp   = bresp_q;
  assign s2axi_o.bid     = bid_q;
  assign s2axi_o.arready = arready_q;
  assign s2axi_o.rvalid  = rvalid_q;
  assign s2axi_o.rdata   = rdata_q;
  assign s2axi_o.rresp   = rresp_q;
  assign s2axi_o.rid     = rid_q;
  assign s2axi_o.rlast   = rvalid_q && (rcnt_q == rlen_q);

endmodule

// File: tb/tb_dma_cfg_slave.sv
// Self-checking bench for dma_cfg_slave: table-driven single-beat accesses
// plus hand-written start/finish, busy, burst and reset sequences.
module tb_dma_cfg_slave;
  import dma_cfg_pkg::*;

  localparam int ID_W   = 8;
  localparam int LEN_W  = 8;
  localparam int BUDGET = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_fin_i;
  logic        dma_en_o;
  logic [31:0] src_addr_o, dst_addr_o, data_qty_o;
  logic        irq_o;

  inf_Slave #(.ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  dma_cfg_slave #(.OFS_MSB(4), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s2axi_i    (bus.S2AXIin),
    .s2axi_o    (bus.S2AXIout),
    .dma_fin_i  (dma_fin_i),
    .dma_en_o   (dma_en_o),
    .src_addr_o (src_addr_o),
    .dst_addr_o (dst_addr_o),
    .data_qty_o (data_qty_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  logic [ID_W-1:0] next_id = 8'h10;

  always @(negedge clk) if (dma_en_o) en_count++;

  typedef struct {
    string           tag;
    bit              is_read;
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
  } exp_t;

  typedef struct {
    string       tag;
    bit          is_read;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[14];

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit sig_now(input int sel);
    case (sel)
      0:       return bus.awready;
      1:       return bus.wready;
      2:       return bus.bvalid;
      3:       return bus.arready;
      default: return bus.rvalid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      if (sig_now(sel)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s: timeout after %0d cycles, required handshake", tag, BUDGET);
  endtask

  task automatic sb_compare(input bit is_read, input logic [ID_W-1:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: unexpected response, queue empty");
      return;
    end
    e = exp_q.pop_front();
    if (is_read) checkOutput(e.tag, 64'({id, data, resp, last}), 64'({e.id, e.data, e.resp, e.last}));
    else         checkOutput(e.tag, 64'({id, resp}), 64'({e.id, e.resp}));
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input string tag, input bit fin_with_beat);
    bit ok;
    exp_q.push_back('{tag, 1'b0, next_id, 32'h0, exp_resp, 1'b1});
    @(negedge clk);
    bus.awaddr = {24'h0, addr};
    bus.awid = next_id;
    bus.awvalid = 1'b1;
    wait_for(0, {tag, "/aw"}, ok);
    if (!ok) begin bus.awvalid = 1'b0; exp_q.delete(); return; end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.wlast = 1'b1;
    bus.wvalid = 1'b1;
    wait_for(1, {tag, "/w"}, ok);
    if (!ok) begin bus.wvalid = 1'b0; exp_q.delete(); return; end
    dma_fin_i = fin_with_beat;
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    dma_fin_i = 1'b0;
    bus.bready = 1'b1;
    wait_for(2, {tag, "/b"}, ok);
    if (ok) sb_compare(1'b0, bus.bid, 32'h0, bus.bresp, 1'b1);
    else exp_q.delete();
    @(negedge clk);
    bus.bready = 1'b0;
    next_id++;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [LEN_W-1:0] len, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag, input int stall_beat);
    bit ok;
    for (int b = 0; b <= int'(len); b++)
      exp_q.push_back('{$sformatf("%s/beat%0d", tag, b), 1'b1, next_id, exp_data, exp_resp, (b == int'(len))});
    @(negedge clk);
    bus.araddr = {24'h0, addr};
    bus.arid = next_id;
    bus.arlen = len;
    bus.arvalid = 1'b1;
    wait_for(3, {tag, "/ar"}, ok);
    if (!ok) begin bus.arvalid = 1'b0; exp_q.delete(); return; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wait_for(4, {tag, "/r"}, ok);
      if (!ok) begin exp_q.delete(); return; end
      if (b == stall_beat) begin
        repeat (2) begin
          @(negedge clk);
          checkOutput({tag, "/stall"}, 64'({bus.rvalid, bus.rdata}), 64'({1'b1, exp_data}));
        end
      end
      sb_compare(1'b1, bus.rid, bus.rdata, bus.rresp, bus.rlast);
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
    end
    next_id++;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_read) axi_read(v.addr, '0, v.data, v.resp, v.tag, -1);
    else           axi_write(v.addr, v.data, v.strb, v.resp, v.tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  e0;
    bit  ok;
    rst = 1'b1;
    dma_fin_i = 1'b0;
    bus.awaddr = '0; bus.awid = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    vecs[0]  = '{"wr_src",      1'b0, 8'h04, 32'h0001_0000, 4'hF, AXI_RESP_OKAY};
    vecs[1]  = '{"wr_dst",      1'b0, 8'h08, 32'h2000_0000, 4'hF, AXI_RESP_OKAY};
    vecs[2]  = '{"wr_qty",      1'b0, 8'h0C, 32'h0000_0040, 4'hF, AXI_RESP_OKAY};
    vecs[3]  = '{"rd_src",      1'b1, 8'h04, 32'h0001_0000, 4'h0, AXI_RESP_OKAY};
    vecs[4]  = '{"wr_src_lane", 1'b0, 8'h04, 32'hAABB_CCDD, 4'h2, AXI_RESP_OKAY};
    vecs[5]  = '{"rd_src_lane", 1'b1, 8'h04, 32'h0001_CC00, 4'h0, AXI_RESP_OKAY};
    vecs[6]  = '{"wr_src_back", 1'b0, 8'h04, 32'h0001_0000, 4'hF, AXI_RESP_OKAY};
    vecs[7]  = '{"rd_dst",      1'b1, 8'h08, 32'h2000_0000, 4'h0, AXI_RESP_OKAY};
    vecs[8]  = '{"rd_qty",      1'b1, 8'h0C, 32'h0000_0040, 4'h0, AXI_RESP_OKAY};
    vecs[9]  = '{"rd_stat_idle",1'b1, 8'h10, 32'h0000_0000, 4'h0, AXI_RESP_OKAY};
    vecs[10] = '{"wr_unmap_1c", 1'b0, 8'h1C, 32'hFFFF_FFFF, 4'hF, AXI_RESP_SLVERR};
    vecs[11] = '{"rd_unmap_1c", 1'b1, 8'h1C, 32'h0000_0000, 4'h0, AXI_RESP_SLVERR};
    vecs[12] = '{"rd_unmap_14", 1'b1, 8'h14, 32'h0000_0000, 4'h0, AXI_RESP_SLVERR};
    vecs[13] = '{"wr_stat_nop", 1'b0, 8'h10, 32'h0000_0000, 4'hF, AXI_RESP_OKAY};

    repeat (3) @(negedge clk);
    checkOutput("rst_src", 64'(src_addr_o), 64'(0));
    checkOutput("rst_dst", 64'(dst_addr_o), 64'(0));
    checkOutput("rst_qty", 64'(data_qty_o), 64'(0));
    checkOutput("rst_ctrl_outs", 64'({dma_en_o, irq_o, bus.bvalid, bus.rvalid, bus.awready}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    $display("[TB] start transfer");
    e0 = en_count;
    axi_write(OFS_CTRL, 32'h3, 4'hF, AXI_RESP_OKAY, "start", 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("dma_en_pulse", 64'(en_count - e0), 64'(1));
    checkOutput("src_out", 64'(src_addr_o), 64'(32'h0001_0000));
    checkOutput("dst_out", 64'(dst_addr_o), 64'(32'h2000_0000));
    checkOutput("qty_out", 64'(data_qty_o), 64'(32'h40));
    axi_read(OFS_STATUS, '0, 32'h1, AXI_RESP_OKAY, "stat_busy", -1);
    axi_read(OFS_CTRL, '0, 32'h2, AXI_RESP_OKAY, "ctrl_no_start", -1);
    checkOutput("irq_while_busy", 64'(irq_o), 64'(0));

    $display("[TB] finish and clear");
    @(negedge clk); dma_fin_i = 1'b1;
    @(negedge clk); dma_fin_i = 1'b0;
    axi_read(OFS_STATUS, '0, 32'h2, AXI_RESP_OKAY, "stat_done", -1);
    checkOutput("irq_done", 64'(irq_o), 64'(1));
    axi_write(OFS_STATUS, 32'h2, 4'hF, AXI_RESP_OKAY, "clr_done", 1'b0);
    checkOutput("irq_cleared", 64'(irq_o), 64'(0));
    axi_read(OFS_STATUS, '0, 32'h0, AXI_RESP_OKAY, "stat_clear", -1);

    $display("[TB] busy protection");
    e0 = en_count;
    axi_write(OFS_CTRL, 32'h3, 4'hF, AXI_RESP_OKAY, "restart", 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("dma_en_pulse2", 64'(en_count - e0), 64'(1));
    axi_write(OFS_SRC, 32'h1234_5678, 4'hF, AXI_RESP_SLVERR, "src_busy", 1'b0);
    checkOutput("src_kept", 64'(src_addr_o), 64'(32'h0001_0000));
    e0 = en_count;
    axi_write(OFS_CTRL, 32'h1, 4'hF, AXI_RESP_SLVERR, "start_busy", 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("no_dma_en_busy", 64'(en_count - e0), 64'(0));
    axi_read(OFS_CTRL, '0, 32'h0, AXI_RESP_OKAY, "ie_written_busy", -1);

    $display("[TB] clear coincident with finish");
    axi_write(OFS_STATUS, 32'h2, 4'hF, AXI_RESP_OKAY, "clr_vs_fin", 1'b1);
    axi_read(OFS_STATUS, '0, 32'h2, AXI_RESP_OKAY, "stat_set_wins", -1);
    checkOutput("irq_ie_off", 64'(irq_o), 64'(0));

    $display("[TB] burst read with stall");
    axi_read(OFS_QTY, 8'd3, 32'h40, AXI_RESP_OKAY, "burst_qty", 1);
    checkOutput("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] reset mid burst");
    @(negedge clk);
    bus.awaddr = 32'h08; bus.awid = 8'h77; bus.awvalid = 1'b1;
    bus.araddr = 32'h04; bus.arid = 8'h78; bus.arlen = 8'd2; bus.arvalid = 1'b1;
    wait_for(0, "rst_burst/aw", ok);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    bus.wdata = 32'h0000_DEAD; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    checkOutput("pre_rst_inflight", 64'({bus.rvalid, bus.wready, dst_addr_o}), 64'({1'b1, 1'b1, 32'h0000_DEAD}));
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valids", 64'({bus.bvalid, bus.rvalid, bus.wready, irq_o, dma_en_o}), 64'(0));
    checkOutput("rst_mid_regs", 64'({src_addr_o, dst_addr_o}), 64'(0));
    checkOutput("rst_mid_qty", 64'(data_qty_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    axi_write(OFS_DST, 32'h0000_0055, 4'hF, AXI_RESP_OKAY, "post_rst_wr", 1'b0);
    axi_read(OFS_DST, '0, 32'h55, AXI_RESP_OKAY, "post_rst_dst", -1);
    axi_read(OFS_SRC, '0, 32'h0, AXI_RESP_OKAY, "post_rst_src", -1);
    axi_read(OFS_STATUS, '0, 32'h0, AXI_RESP_OKAY, "post_rst_stat", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
